sram_emu: RTL and testbench
===========================

SRAM_EMU -- requirements
Module: sram_emu

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the number of low address bits decoded (depth 2^ADDR_W bytes).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the access counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sram_addr  input  21  byte address from the memory controller.
REQ-006 SHALL have port sram_data  inout  8  bidirectional byte bus.
REQ-007 SHALL have port sram_ce  input  1  chip enable, active low.
REQ-008 SHALL have port sram_we  input  1  write enable, active low.
REQ-009 SHALL have port sram_oe  input  1  output enable, active low.
REQ-010 SHALL have port busy  output  1  high when state is not IDLE.
REQ-011 SHALL have port err_contention  output  1  sticky flag: we and oe were sampled low together with ce low.
REQ-012 SHALL have port wr_count  output  CNT_W  number of write bursts accepted.
REQ-013 SHALL have port rd_count  output  CNT_W  number of read bursts accepted.

Function
REQ-014 SHALL sample sram_ce, sram_we, sram_oe, sram_addr and sram_data on every rising clk edge.
REQ-015 SHALL implement states IDLE, WRITE, READ, CONTEND.
- From any state, the next state follows the sampled pins:
  - ce=1 -> IDLE
  - ce=0, we=0, oe=1 -> WRITE
  - ce=0, we=1, oe=0 -> READ
  - ce=0, we=0, oe=0 -> CONTEND
  - ce=0, we=1, oe=1 -> IDLE
REQ-016 SHALL, on each edge where ce=0, we=0 and oe=1, write sram_data to mem[sram_addr[ADDR_W-1:0]].
- Consecutive write cycles to different addresses each write independently.
REQ-017 SHALL ignore sram_addr[20:ADDR_W]; addresses alias modulo 2^ADDR_W.
- Address 2^ADDR_W-1 followed by address+1 wraps to location 0.
REQ-018 SHALL drive sram_data from a read register only when ce=0, oe=0 and we=1 (combinational enable); otherwise sram_data SHALL be high-Z.
REQ-019 SHALL load the read register on every edge with mem[sram_addr[ADDR_W-1:0]].
- Read data therefore appears one cycle after the address is presented.
- Each new address updates the output in the following cycle.
REQ-020 SHALL bypass a same-edge write: if the write address equals the read-register address, the read register SHALL load the written byte.
REQ-021 SHALL never drive sram_data while we=0 or in CONTEND.
REQ-022 SHALL set err_contention in CONTEND; it SHALL clear only on reset.
- A CONTEND cycle SHALL NOT write memory.
REQ-023 SHALL increment wr_count on each IDLE->WRITE transition and rd_count on each IDLE->READ transition.
- A multi-cycle burst counts once; both counters saturate at all-ones.
REQ-024 SHALL treat a WRITE<->READ transition without an intervening IDLE as a new burst and count it.

Reset
REQ-025 SHALL, while reset=0 at an edge, force: state IDLE, busy 0, err_contention 0, wr_count 0, rd_count 0, read register 0x00.
REQ-026 SHALL NOT clear memory contents on reset.
REQ-027 SHALL NOT write memory on an edge where reset=0, including mid-burst.
REQ-028 SHALL float sram_data during reset regardless of the pins.

Structure
REQ-029 SHALL take the state enum (state_t) and the bus width constant SRAM_DW=8 from the shared package, which also holds num.
REQ-030 SHALL place the storage array in one sub-module, sram_emu_mem: single write port, single synchronous read port, with write-first bypass.

Verification
REQ-031 Reset: hold reset=0 for 2 cycles with ce=0, we=0 -> counters 0, err 0, bus Z, memory unchanged.
REQ-032 Two-cycle write: write 0x34 to addr 0x100 and 0x12 to addr 0x101, then a two-cycle read -> bus shows 0x34 then 0x12 one cycle after each address, wr_count=1, rd_count=1.
REQ-033 Wrap: write 0xAA to addr 0x1FFFFF, then read 0xFFF and 0x000 -> 0xAA at 0xFFF.
REQ-034 Contention: ce=0, we=0, oe=0 with 0x55 on bus -> err_contention=1, bus Z, memory unchanged; flag persists through 10 idle cycles.
REQ-035 Bypass: same-cycle write 0x77 to addr 5 while the read register targets 5, then oe=0 -> 0x77 driven.
REQ-036 Saturation: with CNT_W=4, 20 write bursts -> wr_count=15.

Source files
------------

// File: rtl/sram_emu_pkg.sv
// Shared types and constants for the asynchronous-SRAM pin emulator.
package sram_emu_pkg;
  localparam int SRAM_DW = 8;
  localparam int SRAM_AW = 21;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CONTEND} state_t;

  // number of FSM states
  localparam int num = 4;

  // Next state is a pure function of the sampled control pins.
  function automatic state_t decode_pins(input logic ce, input logic we, input logic oe);
    state_t s;
    s = IDLE;
    if (!ce) begin
      case ({we, oe})
        2'b01:   s = WRITE;
        2'b10:   s = READ;
        2'b00:   s = CONTEND;
        default: s = IDLE;
      endcase
    end
    return s;
  endfunction
endpackage

// File: rtl/sram_emu_if.sv
// Address and control pins of the SRAM bus; the data bus stays a top-level inout.
interface sram_emu_if;
  import sram_emu_pkg::*;

  logic [SRAM_AW-1:0] sram_addr;
  logic               sram_ce;
  logic               sram_we;
  logic               sram_oe;

  modport master (output sram_addr, sram_ce, sram_we, sram_oe);
  modport slave  (input  sram_addr, sram_ce, sram_we, sram_oe);
endinterface

// File: rtl/sram_emu_mem.sv
// Byte storage: one write port, one registered read port with write-first bypass.
module sram_emu_mem
  import sram_emu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [SRAM_DW-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [SRAM_DW-1:0] rd_data
);
  logic [SRAM_DW-1:0] mem [0:(1<<ADDR_W)-1];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset)                            rd_data <= '0;
    else if (wr_en && wr_addr == rd_addr)  rd_data <= wr_data;
    else                                   rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sram_emu.sv
// SRAM pin emulator: samples the async SRAM pins each clock, tracks bursts and contention.
module sram_emu
  import sram_emu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  sram_emu_if.slave          bus,
  inout  wire  [SRAM_DW-1:0] sram_data,
  output logic               busy,
  output logic               err_contention,
  output logic [CNT_W-1:0]   wr_count,
  output logic [CNT_W-1:0]   rd_count
);
  state_t             state, state_nxt;
  logic               wr_en, wr_inc, rd_inc, rd_oe;
  logic [SRAM_DW-1:0] rd_q;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^bus.sram_addr[SRAM_AW-1:ADDR_W];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A WRITE<->READ switch without passing IDLE counts as a fresh burst.
  always_comb begin
    state_nxt = decode_pins(bus.sram_ce, bus.sram_we, bus.sram_oe);
    wr_en     = 1'b0;
    wr_inc    = 1'b0;
    rd_inc    = 1'b0;
    if (reset) begin
      wr_en  = (state_nxt == WRITE);
      wr_inc = (state_nxt == WRITE) && (state == IDLE || state == READ);
      rd_inc = (state_nxt == READ)  && (state == IDLE || state == WRITE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_contention <= 1'b0;
      wr_count       <= '0;
      rd_count       <= '0;
    end else begin
      if (state_nxt == CONTEND)          err_contention <= 1'b1;
      if (wr_inc && !(&wr_count))        wr_count <= wr_count + 1'b1;
      if (rd_inc && !(&rd_count))        rd_count <= rd_count + 1'b1;
    end
  end

  assign busy = (state != IDLE);

  sram_emu_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (bus.sram_addr[ADDR_W-1:0]),
    .wr_data (sram_data),
    .rd_addr (bus.sram_addr[ADDR_W-1:0]),
    .rd_data (rd_q)
  );

  // Drive enable follows the live pins so the bus releases as soon as oe/ce rise.
  assign rd_oe     = reset && !bus.sram_ce && !bus.sram_oe && bus.sram_we;
  assign sram_data = rd_oe ? rd_q : {SRAM_DW{1'bz}};
endmodule

// File: tb/tb_sram_emu.sv
// Directed bench for sram_emu: vector table plus corner-case sequences.
module tb_sram_emu;
  logic       clk = 1'b0;
  logic       reset;
  logic       drv;
  logic [7:0] dval;
  wire  [7:0] sram_data;

  logic        busy, err_contention;
  logic [15:0] wr_count, rd_count;
  logic        s_busy, s_err;
  logic [3:0]  s_wr, s_rd;

  int total = 0;
  int passed = 0;

  sram_emu_if bus ();

  assign sram_data = drv ? dval : 8'hzz;

  sram_emu #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sram_data(sram_data),
    .busy(busy), .err_contention(err_contention),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  sram_emu #(.ADDR_W(12), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus), .sram_data(sram_data),
    .busy(s_busy), .err_contention(s_err),
    .wr_count(s_wr), .rd_count(s_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce, we, oe;
    logic [20:0] addr;
    logic        drv;
    logic [7:0]  data;
    logic        chk_bus;
    logic [7:0]  exp_bus;
    logic        exp_busy;
    logic [15:0] exp_wr, exp_rd;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic pins(input logic ce, input logic we, input logic oe,
                      input logic [20:0] a, input logic d_en, input logic [7:0] d);
    bus.sram_ce   = ce;
    bus.sram_we   = we;
    bus.sram_oe   = oe;
    bus.sram_addr = a;
    drv           = d_en;
    dval          = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        ce    we    oe    addr       drv  data   chk  exp    busy wr rd
    vt[0]  = '{1'b1, 1'b1, 1'b1, 21'h000100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'd0, 16'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 21'h000100, 1'b1, 8'h34, 1'b1, 8'h34, 1'b1, 16'd1, 16'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 21'h000101, 1'b1, 8'h12, 1'b1, 8'h12, 1'b1, 16'd1, 16'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 21'h000100, 1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 16'd1, 16'd1};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 21'h000101, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 16'd1, 16'd1};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'd1, 16'd1};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 21'h1FFFFF, 1'b1, 8'hAA, 1'b1, 8'hAA, 1'b1, 16'd2, 16'd1};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 21'h1FF000, 1'b1, 8'hBB, 1'b1, 8'hBB, 1'b1, 16'd2, 16'd1};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 21'h000FFF, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b1, 16'd2, 16'd2};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 21'h000000, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b1, 16'd2, 16'd2};
    vt[10] = '{1'b0, 1'b1, 1'b1, 21'h000000, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 16'd2, 16'd2};
    vt[11] = '{1'b0, 1'b1, 1'b0, 21'h000000, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b1, 16'd2, 16'd3};
    vt[12] = '{1'b0, 1'b0, 1'b1, 21'h000005, 1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 16'd3, 16'd3};
    vt[13] = '{1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'd3, 16'd3};

    // Power-up reset with a write pattern on the pins.
    reset = 1'b0;
    pins(1'b0, 1'b0, 1'b1, 21'h000100, 1'b1, 8'h99);
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_err", err_contention, 0);
    chk("rst_wr", wr_count, 0);
    chk("rst_rd", rd_count, 0);
    chk("rst_bus_float", sram_data, 8'h99);
    chk("rst_sat_wr", s_wr, 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      pins(vt[i].ce, vt[i].we, vt[i].oe, vt[i].addr, vt[i].drv, vt[i].data);
      cyc();
      chk($sformatf("v%0d_busy", i), busy, vt[i].exp_busy);
      chk($sformatf("v%0d_wr", i), wr_count, vt[i].exp_wr);
      chk($sformatf("v%0d_rd", i), rd_count, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), err_contention, 0);
      if (vt[i].chk_bus) chk($sformatf("v%0d_bus", i), sram_data, vt[i].exp_bus);
    end

    // Write-first bypass: mem[5] holds 0x11, overwrite with 0x77 and read the register at once.
    pins(1'b0, 1'b0, 1'b1, 21'h000005, 1'b1, 8'h77);
    cyc();
    chk("byp_wr", wr_count, 4);
    pins(1'b0, 1'b1, 1'b0, 21'h000006, 1'b0, 8'h00);
    #1;
    chk("byp_bus", sram_data, 8'h77);
    cyc();
    chk("byp_rd", rd_count, 4);
    pins(1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00);
    cyc();

    // Contention on an address holding 0x34.
    pins(1'b0, 1'b0, 1'b0, 21'h000100, 1'b1, 8'h55);
    cyc();
    chk("cont_err", err_contention, 1);
    chk("cont_busy", busy, 1);
    chk("cont_bus_float", sram_data, 8'h55);
    chk("cont_wr", wr_count, 4);
    pins(1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00);
    repeat (10) cyc();
    chk("cont_sticky", err_contention, 1);
    chk("cont_idle_busy", busy, 0);
    pins(1'b0, 1'b1, 1'b0, 21'h000100, 1'b0, 8'h00);
    cyc();
    chk("cont_mem_kept", sram_data, 8'h34);
    chk("cont_rd", rd_count, 5);

    // Reset mid-read releases the bus immediately, then blocks a write.
    reset = 1'b0;
    drv = 1'b1; dval = 8'h00;
    #1;
    chk("rst_rd_float", sram_data, 8'h00);
    pins(1'b0, 1'b0, 1'b1, 21'h000100, 1'b1, 8'hEE);
    cyc(); cyc();
    chk("rst2_busy", busy, 0);
    chk("rst2_err", err_contention, 0);
    chk("rst2_wr", wr_count, 0);
    chk("rst2_rd", rd_count, 0);
    chk("rst2_bus_float", sram_data, 8'hEE);
    reset = 1'b1;
    pins(1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00);
    cyc();
    pins(1'b0, 1'b1, 1'b0, 21'h000100, 1'b0, 8'h00);
    cyc();
    chk("rst2_mem_kept", sram_data, 8'h34);
    chk("rst2_rd_after", rd_count, 1);
    pins(1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00);
    cyc();

    // Saturation: 20 single-cycle write bursts.
    for (int i = 0; i < 20; i++) begin
      pins(1'b0, 1'b0, 1'b1, 21'(i), 1'b1, 8'(i));
      cyc();
      pins(1'b1, 1'b1, 1'b1, 21'h000000, 1'b0, 8'h00);
      cyc();
      if (i == 12) begin
        chk("sat_mid_small", s_wr, 13);
        chk("sat_mid_main", wr_count, 13);
      end
    end
    chk("sat_small", s_wr, 15);
    chk("sat_main", wr_count, 20);
    chk("sat_small_rd", s_rd, 1);
    chk("sat_small_err", s_err, 0);
    chk("sat_small_busy", s_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
